// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM states and byte width.
package uart_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side handshake bundle plus the transmitter-side start/data/busy link.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4
);
    localparam int IDW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]                  req_valid;
    logic [NUM_REQ-1:0]                  req_last;
    logic [uart_pkg::BYTE_W*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]                  req_ready;
    logic                                tx_start;
    logic [uart_pkg::BYTE_W-1:0]         txdata;
    logic                                tx_busy;
    logic [IDW-1:0]                      grant_id;
    logic                                lock_active;

    // Arbiter side
    modport master (
        input  req_valid, req_last, req_data, tx_busy,
        output req_ready, tx_start, txdata, grant_id, lock_active
    );

    // Requesters and transmitter side
    modport slave (
        output req_valid, req_last, req_data, tx_busy,
        input  req_ready, tx_start, txdata, grant_id, lock_active
    );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request after ptr_i, wrapping.
module rr_pick #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] ptr_i,
    output logic [N-1:0] grant_o,
    output logic [W-1:0] idx_o,
    output logic         any_o
);

    // Walk offsets from farthest to nearest so the nearest hit after ptr_i wins.
    always_comb begin : pick
        int cand;
        cand  = 0;
        idx_o = '0;
        any_o = 1'b0;
        for (int off = N; off >= 1; off--) begin
            cand = (int'(ptr_i) + off) % N;
            if (req_i[cand]) begin
                idx_o = W'(cand);
                any_o = 1'b1;
            end
        end
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_onehot
        assign grant_o[gi] = any_o && (idx_o == W'(gi));
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte
// producers, with packet lock and optional stalled-lock timeout.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int LOCK_TIMEOUT = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    uart_tx_arbiter_if.master bus
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int CW  = (LOCK_TIMEOUT > 0) ? $clog2(LOCK_TIMEOUT + 1) : 1;
    localparam logic [IDW-1:0] PTR_RST = IDW'(NUM_REQ - 1);

    arb_state_e          state_q, state_d;
    logic [IDW-1:0]      ptr_q;
    logic                lock_q;
    logic [BYTE_W-1:0]   txdata_q;
    logic [CW-1:0]       cnt_q;

    logic [NUM_REQ-1:0]  eligible;
    logic [NUM_REQ-1:0]  pick_grant;
    logic [IDW-1:0]      pick_idx;
    logic                pick_any;
    logic                accept;
    logic                stall;
    logic                timeout_hit;

    // Under lock only the locked requester may compete.
    always_comb begin
        eligible = lock_q ? (bus.req_valid & (NUM_REQ'(1) << ptr_q)) : bus.req_valid;
    end

    rr_pick #(.N(NUM_REQ), .W(IDW)) u_pick (
        .req_i   (eligible),
        .ptr_i   (ptr_q),
        .grant_o (pick_grant),
        .idx_o   (pick_idx),
        .any_o   (pick_any)
    );

    assign accept      = (state_q == IDLE) && !bus.tx_busy && pick_any;
    assign stall       = (state_q == IDLE) && lock_q && !bus.req_valid[ptr_q];
    assign timeout_hit = (LOCK_TIMEOUT > 0) && stall && (cnt_q == CW'(LOCK_TIMEOUT - 1));

    assign bus.req_ready   = accept ? pick_grant : '0;
    assign bus.tx_start    = (state_q == ISSUE);
    assign bus.txdata      = txdata_q;
    assign bus.grant_id    = ptr_q;
    assign bus.lock_active = lock_q;

    // Next-state: accept -> one start cycle -> wait for the transmitter to go idle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (!bus.tx_busy) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, captured byte, pointer, lock and timeout counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ptr_q    <= PTR_RST;
            lock_q   <= 1'b0;
            txdata_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                txdata_q <= bus.req_data[int'(pick_idx)*BYTE_W +: BYTE_W];
                ptr_q    <= pick_idx;
                lock_q   <= !bus.req_last[pick_idx];
                cnt_q    <= '0;
            end else if (state_q != IDLE) begin
                cnt_q <= '0;
            end else if ((LOCK_TIMEOUT > 0) && stall) begin
                if (timeout_hit) begin
                    lock_q <= 1'b0;
                    cnt_q  <= '0;
                end else begin
                    cnt_q <= CW'(cnt_q + 1'b1);
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a simple busy-for-N-cycles transmitter model.
module tb_uart_tx_arbiter;

    localparam int BUSY_LEN = 10;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NUM_REQ(4)) bus();

    uart_tx_arbiter #(.NUM_REQ(4), .LOCK_TIMEOUT(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    int   busy_cnt;
    logic force_busy;
    assign bus.tx_busy = (busy_cnt != 0) || force_busy;

    int   cyc = 0, fall_cyc = 0, n_falls = 0, n_starts = 0, bad_start = 0;
    logic prev_busy = 1'b0;
    int          id_q[$];
    logic [7:0]  dat_q[$];
    int          gap_q[$];

    // Transmitter model and start/busy-fall monitor
    always @(posedge clk) begin
        cyc       <= cyc + 1;
        prev_busy <= bus.tx_busy;
        if (!rst_n)               busy_cnt <= 0;
        else if (bus.tx_start)    busy_cnt <= BUSY_LEN;
        else if (busy_cnt > 0)    busy_cnt <= busy_cnt - 1;
        if (rst_n) begin
            if (prev_busy && !bus.tx_busy) begin
                fall_cyc <= cyc;
                n_falls  <= n_falls + 1;
            end
            if (bus.tx_start) begin
                id_q.push_back(int'(bus.grant_id));
                dat_q.push_back(bus.txdata);
                gap_q.push_back(cyc - fall_cyc);
                n_starts <= n_starts + 1;
                if (bus.tx_busy) bad_start <= bad_start + 1;
                $display("tx: cycle=%0d id=%0d data=%02h lock=%b", cyc, bus.grant_id, bus.txdata, bus.lock_active);
            end
        end
    end

    task automatic reset_dut;
        rst_n         = 1'b0;
        bus.req_valid = '0;
        bus.req_last  = '0;
        bus.req_data  = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_idle(input string tag);
        int k;
        @(negedge clk);
        k = 0;
        while (bus.tx_busy && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (bus.tx_busy) begin
            n_cmp++; n_bad++;
            $display("FAIL %s_idle_bound: tx_busy got %b required 0", tag, bus.tx_busy);
        end
        @(negedge clk);
    endtask

    task automatic wait_ready(input int idx, input string tag);
        int k;
        k = 0;
        #1;
        while (!bus.req_ready[idx] && k < 100) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (!bus.req_ready[idx]) begin
            n_cmp++; n_bad++;
            $display("FAIL %s_ready_bound: req_ready[%0d] got 0 required 1", tag, idx);
        end
    endtask

    task automatic test_reset;
        reset_dut();
        n_cmp++; if (bus.tx_start !== 1'b0)   begin n_bad++; $display("FAIL reset_tx_start: got %b required 0", bus.tx_start); end
        n_cmp++; if (bus.txdata !== 8'h00)    begin n_bad++; $display("FAIL reset_txdata: got %h required 00", bus.txdata); end
        n_cmp++; if (bus.req_ready !== 4'b0)  begin n_bad++; $display("FAIL reset_ready: got %b required 0000", bus.req_ready); end
        n_cmp++; if (bus.lock_active !== 1'b0) begin n_bad++; $display("FAIL reset_lock: got %b required 0", bus.lock_active); end
        n_cmp++; if (bus.grant_id !== 2'd3)   begin n_bad++; $display("FAIL reset_grant_id: got %0d required 3", bus.grant_id); end
    endtask

    task automatic test_single;
        bus.req_data[23:16] = 8'hA5;
        bus.req_last[2]     = 1'b1;
        bus.req_valid[2]    = 1'b1;
        #1;
        n_cmp++; if (bus.req_ready !== 4'b0100) begin n_bad++; $display("FAIL single_ready: got %b required 0100", bus.req_ready); end
        @(negedge clk);
        bus.req_valid[2] = 1'b0;
        n_cmp++; if (bus.tx_start !== 1'b1)    begin n_bad++; $display("FAIL single_start: got %b required 1", bus.tx_start); end
        n_cmp++; if (bus.txdata !== 8'hA5)     begin n_bad++; $display("FAIL single_txdata: got %h required a5", bus.txdata); end
        n_cmp++; if (bus.grant_id !== 2'd2)    begin n_bad++; $display("FAIL single_grant: got %0d required 2", bus.grant_id); end
        n_cmp++; if (bus.lock_active !== 1'b0) begin n_bad++; $display("FAIL single_lock: got %b required 0", bus.lock_active); end
        n_cmp++; if (bus.req_ready !== 4'b0)   begin n_bad++; $display("FAIL single_ready_issue: got %b required 0000", bus.req_ready); end
        @(negedge clk);
        n_cmp++; if (bus.tx_start !== 1'b0)    begin n_bad++; $display("FAIL single_start_width: got %b required 0", bus.tx_start); end
        n_cmp++; if (bus.txdata !== 8'hA5)     begin n_bad++; $display("FAIL single_txdata_hold: got %h required a5", bus.txdata); end
        wait_idle("single");
    endtask

    task automatic test_round_robin;
        int base, bf, bb, k;
        int exp_id[5];
        exp_id = '{0, 1, 2, 3, 0};
        reset_dut();
        base = n_starts; bf = n_falls; bb = bad_start;
        for (int i = 0; i < 4; i++) bus.req_data[8*i +: 8] = 8'hC0 + 8'(i);
        bus.req_last  = 4'hF;
        bus.req_valid = 4'hF;
        k = 0;
        while ((n_starts - base) < 5 && k < 400) begin
            @(negedge clk);
            k++;
        end
        bus.req_valid = '0;
        wait_idle("rr");
        n_cmp++;
        if (id_q.size() < base + 5) begin
            n_bad++; $display("FAIL rr_count: got %0d starts required 5", id_q.size() - base);
        end else begin
            for (int j = 0; j < 5; j++) begin
                n_cmp++; if (id_q[base+j] !== exp_id[j]) begin n_bad++; $display("FAIL rr_order[%0d]: got %0d required %0d", j, id_q[base+j], exp_id[j]); end
                n_cmp++; if (dat_q[base+j] !== 8'(8'hC0 + exp_id[j])) begin n_bad++; $display("FAIL rr_data[%0d]: got %h required %h", j, dat_q[base+j], 8'(8'hC0 + exp_id[j])); end
                if (j > 0) begin
                    n_cmp++; if (gap_q[base+j] !== 2) begin n_bad++; $display("FAIL rr_gap[%0d]: got %0d cycles required 2", j, gap_q[base+j]); end
                end
            end
        end
        n_cmp++; if ((n_falls - bf) !== (n_starts - base)) begin n_bad++; $display("FAIL rr_start_per_busy: got %0d starts for %0d busy periods", n_starts - base, n_falls - bf); end
        n_cmp++; if ((bad_start - bb) !== 0) begin n_bad++; $display("FAIL rr_start_while_busy: got %0d required 0", bad_start - bb); end
    endtask

    task automatic test_lock;
        int base;
        int   exp_id[4];
        logic [7:0] exp_d[4];
        logic exp_l;
        exp_id = '{1, 1, 1, 0};
        exp_d  = '{8'h10, 8'h11, 8'h12, 8'h50};
        base = n_starts;
        bus.req_data[7:0] = 8'h50;
        bus.req_last[0]   = 1'b1;
        bus.req_valid[0]  = 1'b1;
        for (int b = 0; b < 3; b++) begin
            bus.req_data[15:8] = 8'h10 + 8'(b);
            bus.req_last[1]    = (b == 2);
            bus.req_valid[1]   = 1'b1;
            wait_ready(1, "lock");
            exp_l = (b != 0);
            n_cmp++; if (bus.lock_active !== exp_l) begin n_bad++; $display("FAIL lock_before[%0d]: got %b required %b", b, bus.lock_active, exp_l); end
            @(negedge clk);
            exp_l = (b != 2);
            n_cmp++; if (bus.lock_active !== exp_l) begin n_bad++; $display("FAIL lock_after[%0d]: got %b required %b", b, bus.lock_active, exp_l); end
            if (b == 2) bus.req_valid[1] = 1'b0;
        end
        wait_ready(0, "lock");
        n_cmp++; if (bus.lock_active !== 1'b0) begin n_bad++; $display("FAIL lock_release: got %b required 0", bus.lock_active); end
        @(negedge clk);
        bus.req_valid[0] = 1'b0;
        wait_idle("lock");
        n_cmp++;
        if (id_q.size() < base + 4) begin
            n_bad++; $display("FAIL lock_count: got %0d starts required 4", id_q.size() - base);
        end else begin
            for (int j = 0; j < 4; j++) begin
                n_cmp++; if (id_q[base+j] !== exp_id[j]) begin n_bad++; $display("FAIL lock_order[%0d]: got %0d required %0d", j, id_q[base+j], exp_id[j]); end
                n_cmp++; if (dat_q[base+j] !== exp_d[j]) begin n_bad++; $display("FAIL lock_data[%0d]: got %h required %h", j, dat_q[base+j], exp_d[j]); end
            end
        end
    endtask

    task automatic test_timeout;
        bus.req_data[31:24] = 8'h3C;
        bus.req_last[3]     = 1'b0;
        bus.req_valid[3]    = 1'b1;
        bus.req_data[7:0]   = 8'h0D;
        bus.req_last[0]     = 1'b1;
        bus.req_valid[0]    = 1'b1;
        wait_ready(3, "timeout");
        @(negedge clk);
        bus.req_valid[3] = 1'b0;
        n_cmp++; if (bus.lock_active !== 1'b1) begin n_bad++; $display("FAIL to_lock_set: got %b required 1", bus.lock_active); end
        wait_idle("timeout");
        for (int c = 0; c < 5; c++) begin
            #1;
            n_cmp++; if (bus.lock_active !== 1'b1) begin n_bad++; $display("FAIL to_lock_held[%0d]: got %b required 1", c, bus.lock_active); end
            n_cmp++; if (bus.req_ready !== 4'b0)   begin n_bad++; $display("FAIL to_no_ready[%0d]: got %b required 0000", c, bus.req_ready); end
            @(negedge clk);
        end
        #1;
        n_cmp++; if (bus.lock_active !== 1'b0)   begin n_bad++; $display("FAIL to_lock_clear: got %b required 0", bus.lock_active); end
        n_cmp++; if (bus.req_ready !== 4'b0001)  begin n_bad++; $display("FAIL to_ready0: got %b required 0001", bus.req_ready); end
        @(negedge clk);
        bus.req_valid[0] = 1'b0;
        n_cmp++; if (bus.tx_start !== 1'b1)  begin n_bad++; $display("FAIL to_start: got %b required 1", bus.tx_start); end
        n_cmp++; if (bus.txdata !== 8'h0D)   begin n_bad++; $display("FAIL to_txdata: got %h required 0d", bus.txdata); end
        wait_idle("timeout2");
    endtask

    task automatic test_reset_mid;
        bus.req_data[23:16] = 8'h77;
        bus.req_last[2]     = 1'b0;
        bus.req_valid[2]    = 1'b1;
        wait_ready(2, "rstmid");
        @(negedge clk);
        bus.req_valid[2] = 1'b0;
        @(negedge clk);
        n_cmp++; if (bus.lock_active !== 1'b1) begin n_bad++; $display("FAIL rstmid_lock_pre: got %b required 1", bus.lock_active); end
        rst_n = 1'b0;
        @(negedge clk);
        n_cmp++; if (bus.tx_start !== 1'b0)    begin n_bad++; $display("FAIL rstmid_start: got %b required 0", bus.tx_start); end
        n_cmp++; if (bus.txdata !== 8'h00)     begin n_bad++; $display("FAIL rstmid_txdata: got %h required 00", bus.txdata); end
        n_cmp++; if (bus.lock_active !== 1'b0) begin n_bad++; $display("FAIL rstmid_lock: got %b required 0", bus.lock_active); end
        n_cmp++; if (bus.req_ready !== 4'b0)   begin n_bad++; $display("FAIL rstmid_ready: got %b required 0000", bus.req_ready); end
        n_cmp++; if (bus.grant_id !== 2'd3)    begin n_bad++; $display("FAIL rstmid_grant: got %0d required 3", bus.grant_id); end
        rst_n = 1'b1;
        bus.req_data[7:0]   = 8'h01;
        bus.req_data[23:16] = 8'h02;
        bus.req_last        = 4'b0101;
        bus.req_valid       = 4'b0101;
        #1;
        n_cmp++; if (bus.req_ready !== 4'b0001) begin n_bad++; $display("FAIL rstmid_first_ready: got %b required 0001", bus.req_ready); end
        @(negedge clk);
        bus.req_valid[0] = 1'b0;
        n_cmp++; if (bus.tx_start !== 1'b1)  begin n_bad++; $display("FAIL rstmid_start0: got %b required 1", bus.tx_start); end
        n_cmp++; if (bus.txdata !== 8'h01)   begin n_bad++; $display("FAIL rstmid_data0: got %h required 01", bus.txdata); end
        n_cmp++; if (bus.grant_id !== 2'd0)  begin n_bad++; $display("FAIL rstmid_grant0: got %0d required 0", bus.grant_id); end
        wait_ready(2, "rstmid2");
        @(negedge clk);
        bus.req_valid[2] = 1'b0;
        n_cmp++; if (bus.txdata !== 8'h02)   begin n_bad++; $display("FAIL rstmid_data2: got %h required 02", bus.txdata); end
        n_cmp++; if (bus.grant_id !== 2'd2)  begin n_bad++; $display("FAIL rstmid_grant2: got %0d required 2", bus.grant_id); end
        wait_idle("rstmid");
    endtask

    task automatic test_busy_hold;
        force_busy        = 1'b1;
        bus.req_data[7:0] = 8'h99;
        bus.req_last[0]   = 1'b1;
        bus.req_valid[0]  = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            n_cmp++; if (bus.req_ready !== 4'b0) begin n_bad++; $display("FAIL busy_no_ready[%0d]: got %b required 0000", c, bus.req_ready); end
            @(negedge clk);
        end
        force_busy = 1'b0;
        #1;
        n_cmp++; if (bus.req_ready !== 4'b0001) begin n_bad++; $display("FAIL busy_release_ready: got %b required 0001", bus.req_ready); end
        @(negedge clk);
        bus.req_valid[0] = 1'b0;
        n_cmp++; if (bus.tx_start !== 1'b1) begin n_bad++; $display("FAIL busy_start: got %b required 1", bus.tx_start); end
        n_cmp++; if (bus.txdata !== 8'h99)  begin n_bad++; $display("FAIL busy_txdata: got %h required 99", bus.txdata); end
        wait_idle("busy");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        force_busy = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_lock();
        test_timeout();
        test_reset_mid();
        test_busy_hold();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
